mem_access: RTL
===============

Name: mem_access

Overview:
- Memory-access (MA) stage. Sits directly downstream of the execute stage's EX/MA pipeline register.
- For loads and stores it drives a single-outstanding data-bus transaction and aligns store data/strobes. It extracts and sign/zero-extends load data and reports misaligned-access and bus-error faults.
- Registers the retiring instruction into the MA/WB register, and holds the upstream pipeline (busy) while a bus access is in flight.

Parameters:
- BUS_TIMEOUT, 256, cycles to wait for mem_rvalid after request acceptance before raising an access fault; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clear  in  1  pipeline flush; kills the MA/WB output and any in-flight access
- stall  in  1  downstream/global stall; freezes the MA/WB register
- in_valid  in  1  EX/MA slot holds a live instruction
- pc_in  in  64  instruction PC
- rd_in  in  5  destination register
- result_in  in  64  ALU/CSR result; the effective address for loads/stores
- data2_in  in  64  store data (rs2)
- ld_op  in  1  load
- st_op  in  1  store
- size  in  2  access size: 0=B, 1=H, 2=W, 3=D
- ld_unsigned  in  1  zero-extend load data
- mem_req  out  1  bus request valid
- mem_we  out  1  1 = write
- mem_addr  out  64  8-byte-aligned address
- mem_wstrb  out  8  byte strobes
- mem_wdata  out  64  lane-replicated store data
- mem_ready  in  1  request accepted
- mem_rvalid  in  1  response valid (load data or store ack)
- mem_rdata  in  64  response data
- mem_err  in  1  response carries a bus error, qualified by mem_rvalid
- busy  out  1  hold the upstream stages
- fault_en  out  1  one-cycle fault pulse
- fault_cause  out  4  4=load misaligned, 5=load access fault, 6=store misaligned, 7=store access fault
- fault_addr  out  64  faulting effective address
- valid_out  out  1  MA/WB slot valid
- pc_out  out  64  registered PC
- rd_out  out  5  registered rd; forced to 0 for stores and faults
- result_out  out  64  load data or passthrough result

Behaviour:
- Reset: FSM is IDLE, timeout counter is 0, and every output is 0.
- FSM states:
  - IDLE: a non-memory instruction (in_valid, no ld_op/st_op) with stall=0 is registered to MA/WB next cycle. busy=0; result_out=result_in; latency 1.
  - IDLE, ld_op|st_op with in_valid:
    - Misaligned address (addr[0] for H, addr[1:0] for W, addr[2:0] for D nonzero): no bus request.
    - The same cycle, fault_en=1 with cause 4/6 and fault_addr=result_in; valid_out=0 next cycle.
    - Otherwise go to REQ; busy=1 from that same cycle (combinational).
  - REQ: mem_req=1 with address/strobes/data held stable until mem_ready. Going to WAIT is on mem_req&mem_ready. mem_rvalid in the same cycle as mem_ready is legal: go straight to DONE.
  - WAIT: the counter increments each cycle. On mem_rvalid go to DONE. If the counter reaches BUS_TIMEOUT-1 without mem_rvalid, treat it as mem_err.
  - DONE: one cycle; busy=0. MA/WB is loaded when stall=0; DONE holds while stall=1. Then go to IDLE.
- Store lanes:
  - mem_wstrb = size mask << addr[2:0], where the size masks are 0x01, 0x03, 0x0F, 0xFF.
  - mem_wdata = data2_in low bytes replicated across all lanes.
- Load extraction:
  - Take mem_rdata >> (8*addr[2:0]) and truncate to the access size.
  - Sign-extend unless ld_unsigned; size=3 ignores ld_unsigned.
- mem_err: fault_en pulses in the DONE cycle with cause 5/7; valid_out=0.
- Operand capture: the address, size, flags, pc and rd are captured into internal registers on leaving IDLE. EX inputs may change while busy.
- clear:
  - In IDLE/DONE, clear invalidates the next MA/WB contents.
  - In REQ before acceptance, clear drops mem_req next cycle.
  - In WAIT, clear moves the FSM to DRAIN: busy=1, and the response is absorbed and discarded, including errors. Then go to IDLE. No fault, no writeback.
- rst mid-access: unconditional return to IDLE the next cycle. The bus master is reset with the core.
- Simultaneous clear and fault: clear wins; no fault_en.

Decomposition:
- Shared package (isa package): access-size encoding, fault cause codes, the FSM state enum (IDLE, REQ, WAIT, DONE, DRAIN).
- One sub-module, mem_align: purely combinational store strobe/data generation plus load extract/extend. The FSM, counter and MA/WB register stay in mem_access.

Test Plan:
- SW addr 0x1004, data2=0xAABBCCDD_11223344, mem_ready=1 → mem_wstrb=0xF0, mem_wdata=0x11223344_11223344; rd_out=0, no fault.
- LB addr 0x1003, mem_rdata=0x00000000_80000000 after 3 wait cycles → busy for 5 cycles, result_out=0xFFFFFFFFFFFFFF80. Repeat with LBU → 0x80.
- LW addr 0x1002 → fault_en same cycle, cause 4, fault_addr 0x1002, mem_req never asserted.
- LD with mem_rvalid=1 and mem_err=1 → cause 5, valid_out=0. Second run: BUS_TIMEOUT=4 with no response → cause 5 after 4 WAIT cycles.
- Load in WAIT, clear asserted, response arrives 2 cycles later → busy until the response, no writeback, no fault, next ADD passes with 1-cycle latency.
- ADD result 0x5 with stall=1 for 2 cycles → MA/WB holds the previous value, then loads 0x5. rst during REQ → mem_req=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: access sizes, fault causes and FSM states.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } ma_state_t;

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
        case (size_t'(sz))
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = a[0];
            SZ_W:    misaligned = |a[1:0];
            default: misaligned = |a;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (size_t'(sz))
            SZ_B:    size_mask = 8'h01;
            SZ_H:    size_mask = 8'h03;
            SZ_W:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: store strobe/data replication and load extract/extend.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  addr_lo,
    input  logic        ld_unsigned,
    input  logic [63:0] st_data,
    input  logic [63:0] rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata,
    output logic [63:0] ld_data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        wstrb   = size_mask(size) << addr_lo;
        wdata   = st_data;
        ld_data = shifted;
        case (size_t'(size))
            SZ_B: begin
                wdata   = {8{st_data[7:0]}};
                ld_data = ld_unsigned ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wdata   = {4{st_data[15:0]}};
                ld_data = ld_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                wdata   = {2{st_data[31:0]}};
                ld_data = ld_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            end
            default: begin
                wdata   = st_data;
                ld_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: single-outstanding data-bus master, fault reporting
// and the MA/WB pipeline register.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        stall,
    input  logic        in_valid,
    input  logic [63:0] pc_in,
    input  logic [4:0]  rd_in,
    input  logic [63:0] result_in,
    input  logic [63:0] data2_in,
    input  logic        ld_op,
    input  logic        st_op,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wstrb,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    output logic        busy,
    output logic        fault_en,
    output logic [3:0]  fault_cause,
    output logic [63:0] fault_addr,
    output logic        valid_out,
    output logic [63:0] pc_out,
    output logic [4:0]  rd_out,
    output logic [63:0] result_out
);

    ma_state_t   state, state_nxt;
    logic [31:0] tmo_cnt;
    logic [63:0] cap_addr, cap_pc, cap_wdata, rdata_q;
    logic [4:0]  cap_rd;
    logic [1:0]  cap_size;
    logic        cap_uns, cap_st, err_q;
    logic        is_mem, timeout;
    logic [7:0]  al_wstrb;
    logic [63:0] al_wdata, al_ld;

    mem_align u_align (
        .size        (cap_size),
        .addr_lo     (cap_addr[2:0]),
        .ld_unsigned (cap_uns),
        .st_data     (cap_wdata),
        .rdata       (rdata_q),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .ld_data     (al_ld)
    );

    assign is_mem  = in_valid & (ld_op | st_op);
    assign timeout = (BUS_TIMEOUT != 32'd0) && (tmo_cnt == BUS_TIMEOUT - 32'd1);

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        mem_req     = 1'b0;
        fault_en    = 1'b0;
        fault_cause = '0;
        fault_addr  = '0;
        case (state)
            S_IDLE: begin
                if (is_mem && !clear && !stall) begin
                    if (misaligned(size, result_in[2:0])) begin
                        fault_en    = 1'b1;
                        fault_cause = st_op ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                        fault_addr  = result_in;
                    end else begin
                        busy      = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                // An accepted request under clear still owes a response, so it drains.
                if (mem_ready) begin
                    if (mem_rvalid) state_nxt = clear ? S_IDLE : S_DONE;
                    else            state_nxt = clear ? S_DRAIN : S_WAIT;
                end else if (clear) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (mem_rvalid || timeout) state_nxt = clear ? S_IDLE : S_DONE;
                else if (clear)            state_nxt = S_DRAIN;
            end
            S_DONE: begin
                if (clear) begin
                    state_nxt = S_IDLE;
                end else if (!stall) begin
                    state_nxt = S_IDLE;
                    if (err_q) begin
                        fault_en    = 1'b1;
                        fault_cause = cap_st ? CAUSE_ST_ACCESS : CAUSE_LD_ACCESS;
                        fault_addr  = cap_addr;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (mem_rvalid || timeout) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (state == S_REQ) begin
            mem_we    = cap_st;
            mem_addr  = {cap_addr[63:3], 3'b000};
            mem_wstrb = cap_st ? al_wstrb : 8'h00;
            mem_wdata = cap_st ? al_wdata : 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            cap_addr  <= '0;
            cap_pc    <= '0;
            cap_wdata <= '0;
            cap_rd    <= '0;
            cap_size  <= '0;
            cap_uns   <= 1'b0;
            cap_st    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= (state == S_WAIT || state == S_DRAIN) ? tmo_cnt + 32'd1 : '0;
            if (state == S_IDLE && state_nxt == S_REQ) begin
                cap_addr  <= result_in;
                cap_pc    <= pc_in;
                cap_wdata <= data2_in;
                cap_rd    <= rd_in;
                cap_size  <= size;
                cap_uns   <= ld_unsigned;
                cap_st    <= st_op;
            end
            if (state_nxt == S_DONE && state != S_DONE) begin
                err_q   <= mem_rvalid ? mem_err : 1'b1;
                rdata_q <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            pc_out     <= '0;
            rd_out     <= '0;
            result_out <= '0;
        end else if (clear) begin
            valid_out <= 1'b0;
            rd_out    <= '0;
        end else if (!stall) begin
            case (state)
                S_IDLE: begin
                    valid_out  <= in_valid & ~(ld_op | st_op);
                    pc_out     <= pc_in;
                    rd_out     <= (in_valid & ~(ld_op | st_op)) ? rd_in : 5'd0;
                    result_out <= result_in;
                end
                S_DONE: begin
                    valid_out  <= ~err_q;
                    pc_out     <= cap_pc;
                    rd_out     <= (cap_st | err_q) ? 5'd0 : cap_rd;
                    result_out <= cap_st ? cap_addr : al_ld;
                end
                default: begin
                    valid_out <= 1'b0;
                    rd_out    <= '0;
                end
            endcase
        end
    end

endmodule
